// File: rtl/lsu_controller.sv
// Load-store sequencer: latches a core access, drives the data memory handshake,
// formats load data and reports misaligned/unsupported accesses and memory timeouts.
module lsu_controller #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        access_err_o,
  output logic        bus_err_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [31:0]     r_addr, r_wd, r_rd;
  logic            r_we, r_access_err, r_bus_err;
  logic [2:0]      r_size;
  logic [CW-1:0]   r_cnt;
  logic            w_illegal, w_timeout;
  logic [31:0]     w_shift, w_load;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  always_comb begin
    w_illegal = 1'b0;
    case (core_size_i)
      3'd0:    w_illegal = 1'b0;
      3'd1:    w_illegal = core_addr_i[0];
      3'd2:    w_illegal = (core_addr_i[1:0] != 2'b00);
      3'd4:    w_illegal = core_we_i;
      3'd5:    w_illegal = core_we_i | core_addr_i[0];
      default: w_illegal = 1'b1;
    endcase
  end

  // Reaching TIMEOUT-1 with ready still low means this is the last permitted BUSY cycle.
  assign w_timeout = (TIMEOUT > 0) && (r_cnt == CW'(TIMEOUT - 1));

  assign w_shift = mem_rd_i >> {r_addr[1:0], 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_addr[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

  always_comb begin
    w_load = mem_rd_i;
    case (r_size)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd4:    w_load = {24'd0, w_byte};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = mem_rd_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_be_o  = 4'b0000;
    case (r_state)
      S_IDLE: if (core_req_i) w_next = w_illegal ? S_DONE : S_BUSY;
      S_BUSY: begin
        mem_req_o = 1'b1;
        mem_we_o  = r_we;
        case (r_size)
          3'd0, 3'd4: mem_be_o = 4'b0001 << r_addr[1:0];
          3'd1, 3'd5: mem_be_o = 4'b0011 << r_addr[1:0];
          default:    mem_be_o = 4'b1111;
        endcase
        if (mem_ready_i || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr       <= 32'd0;
      r_wd         <= 32'd0;
      r_rd         <= 32'd0;
      r_we         <= 1'b0;
      r_size       <= 3'd0;
      r_cnt        <= '0;
      r_access_err <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (core_req_i) begin
          r_addr       <= core_addr_i;
          r_we         <= core_we_i;
          r_size       <= core_size_i;
          r_wd         <= core_wd_i;
          r_cnt        <= '0;
          r_rd         <= 32'd0;
          r_access_err <= w_illegal;
        end
        S_BUSY: begin
          if (mem_ready_i) begin
            r_rd <= r_we ? 32'd0 : w_load;
          end else if (w_timeout) begin
            r_rd      <= 32'd0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_access_err <= 1'b0;
          r_bus_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Gated by reset so the stall also drops asynchronously.
  assign core_stall_o = rst_ni & core_req_i & (r_state != S_DONE);
  assign core_rd_o    = r_rd;
  assign access_err_o = r_access_err;
  assign bus_err_o    = r_bus_err;
  assign mem_addr_o   = {r_addr[31:2], 2'b00};

  always_comb begin
    mem_wd_o = r_wd;
    case (r_size)
      3'd0, 3'd4: mem_wd_o = {4{r_wd[7:0]}};
      3'd1, 3'd5: mem_wd_o = {2{r_wd[15:0]}};
      default:    mem_wd_o = r_wd;
    endcase
  end

endmodule
